// File: rtl/fb_wp_pkg.sv
// Shared definitions for the framebuffer write port: register map, STATUS layout, FSM states.
package fb_wp_pkg;

  localparam logic [1:0] SEL_PTR    = 2'd0;
  localparam logic [1:0] SEL_DATA   = 2'd1;
  localparam logic [1:0] SEL_FILL   = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } state_e;

  function automatic logic [15:0] status_word(input logic empty, input logic full,
                                              input logic busy, input logic ovf);
    logic [15:0] s;
    s = '0;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    s[ST_BUSY]  = busy;
    s[ST_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/fb_wp_fifo.sv
// Synchronous FIFO holding {addr, data} framebuffer writes; combinational read of the head entry.
module fb_wp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_port.sv
// CPU write port into the VGA framebuffer: buffered byte writes plus a whole-buffer fill engine.
// Define FB_WP_VBLANK_ONLY_EN to restrict framebuffer writes to the (synchronized) vblank window.
module fb_write_port
  import fb_wp_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic [1:0]        cpu_sel,
  input  logic [15:0]       cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              vblank,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_we
);

  localparam int EW = ADDR_W + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] ptr_q, fill_cnt_q;
  logic [DATA_W-1:0] fill_val_q;
  logic              fill_pend_q, ovf_q;
  logic [15:0]       rdata_q, rdata_d;
  state_e            state_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [DATA_W-1:0] fb_data_q;
  logic              fb_we_q;

  logic          f_push, f_pop, f_full, f_empty;
  logic [EW-1:0] f_rdata;
  logic [CW-1:0] f_count;
  logic          go, wr_data, wr_fill, wr_stat, drop, fill_step, fill_last, busy;

`ifdef FB_WP_VBLANK_ONLY_EN
  logic vb_meta_q, vb_sync_q;
  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      vb_meta_q <= 1'b0;
      vb_sync_q <= 1'b0;
    end else begin
      vb_meta_q <= vblank;
      vb_sync_q <= vb_meta_q;
    end
  end
  assign go = vb_sync_q;
  logic unused_bits;
  assign unused_bits = ^cpu_wdata;
`else
  assign go = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{cpu_wdata, vblank};
`endif

  // Ready depends only on registers so the CPU side never sees a combinational path from its own strobes.
  assign cpu_ready = !f_full && !fill_pend_q && (state_q != FILL);
  assign busy      = fill_pend_q || (state_q == FILL);

  assign wr_data = cpu_we && (cpu_sel == SEL_DATA);
  assign wr_fill = cpu_we && (cpu_sel == SEL_FILL);
  assign wr_stat = cpu_we && (cpu_sel == SEL_STATUS);
  assign drop    = (wr_data || wr_fill) && !cpu_ready;
  assign f_push  = wr_data && cpu_ready;

  // Popping straight out of IDLE keeps DATA-write latency at two cycles.
  assign f_pop     = go && !f_empty && ((state_q == IDLE) || (state_q == DRAIN));
  assign fill_step = go && ((state_q == FILL) || ((state_q == IDLE) && f_empty && fill_pend_q));
  assign fill_last = fill_step && (fill_cnt_q == '1);

  fb_wp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk50),
    .rst_n   (rst),
    .push_i  (f_push),
    .wdata_i ({ptr_q, cpu_wdata[DATA_W-1:0]}),
    .pop_i   (f_pop),
    .rdata_o (f_rdata),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      fill_pend_q <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!f_empty)         state_q <= DRAIN;
          else if (fill_pend_q) state_q <= FILL;
        end
        DRAIN:   if (f_empty)   state_q <= IDLE;
        FILL:    if (fill_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // The counter wraps back to zero after the last address, ready for the next fill.
      if (fill_step) fill_cnt_q <= fill_cnt_q + A_ONE;

      if (wr_fill && cpu_ready) fill_pend_q <= 1'b1;
      else if (fill_last)       fill_pend_q <= 1'b0;

      fb_we_q <= f_pop || fill_step;
      if (f_pop) begin
        fb_addr_q <= f_rdata[EW-1 -: ADDR_W];
        fb_data_q <= f_rdata[DATA_W-1:0];
      end else if (fill_step) begin
        fb_addr_q <= fill_cnt_q;
        fb_data_q <= fill_val_q;
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (cpu_re) begin
      case (cpu_sel)
        SEL_PTR:  rdata_d = 16'(ptr_q);
        SEL_DATA: rdata_d = 16'(f_count);
        SEL_FILL: rdata_d = 16'(fill_val_q);
        default:  rdata_d = status_word(f_empty, f_full, busy, ovf_q);
      endcase
    end
  end

  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      fill_val_q <= '0;
      ovf_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (cpu_we && (cpu_sel == SEL_PTR)) ptr_q <= cpu_wdata[ADDR_W-1:0];
      else if (f_push)                    ptr_q <= ptr_q + A_ONE;
      if (wr_fill && cpu_ready) fill_val_q <= cpu_wdata[DATA_W-1:0];
      ovf_q <= drop || (ovf_q && !wr_stat);
    end
  end

  assign cpu_rdata = rdata_q;
  assign fb_addr   = fb_addr_q;
  assign fb_data   = fb_data_q;
  assign fb_we     = fb_we_q;

endmodule

// File: tb/tb_fb_write_port.sv
// Directed bench for fb_write_port with an {addr,data} scoreboard of expected framebuffer writes.
module tb_fb_write_port;
  import fb_wp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cpu_sel = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0, cpu_re = 1'b0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        vblank;
  logic [11:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;

  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] sb[$];
  logic [11:0] ptr_m = '0;
  int run_len = 0, last_run = 0;

  fb_write_port #(.FIFO_DEPTH(8), .ADDR_W(12), .DATA_W(8)) dut (
    .clk50(clk), .rst(rst_n), .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .vblank(vblank), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every fb_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else if (fb_we === 1'b1) begin
      run_len++;
      check("we_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("fb_write", {12'b0, fb_addr, fb_data}, {12'b0, sb.pop_front()});
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

`ifdef FB_WP_VBLANK_ONLY_EN
  logic [2:0] vb_hist = '0;
  always @(posedge clk) vb_hist <= {vb_hist[1:0], vblank};
  always @(negedge clk) begin
    if (rst_n && fb_we === 1'b1) check("we_in_vblank", 32'(vb_hist[2]), 32'd1);
  end
`endif

  task automatic wr(input logic [1:0] sel, input logic [15:0] d, input bit acc = 1'b1);
    if (sel == SEL_DATA || sel == SEL_FILL) check("ready_before_wr", 32'(cpu_ready), 32'(acc));
    cpu_sel = sel; cpu_wdata = d; cpu_we = 1'b1;
    if (sel == SEL_PTR) ptr_m = d[11:0];
    if (sel == SEL_DATA && acc) begin
      sb.push_back({ptr_m, d[7:0]});
      ptr_m = ptr_m + 12'd1;
    end
    if (sel == SEL_FILL && acc)
      for (int i = 0; i < 4096; i++) sb.push_back({12'(i), d[7:0]});
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [15:0] exp);
    cpu_sel = sel; cpu_re = 1'b1;
    @(negedge clk);
    cpu_re = 1'b0;
    check(tag, 32'(cpu_rdata), 32'(exp));
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((sb.size() != 0 || fb_we === 1'b1) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < bound), 32'd1);
    @(negedge clk);
  endtask

  initial begin
`ifdef FB_WP_VBLANK_ONLY_EN
    vblank = 1'b1;
`else
    vblank = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd("status_after_rst", SEL_STATUS, 16'h0001);

    // Two-cycle write latency and pointer auto-increment.
    wr(SEL_PTR, 16'h0100);
    wr(SEL_DATA, 16'h00AA);
    check("lat_e_plus1", 32'(fb_we), 32'd0);
    wr(SEL_DATA, 16'h00BB);
    check("lat_e_plus2_we", 32'(fb_we), 32'd1);
    check("lat_e_plus2_addr", 32'(fb_addr), 32'h100);
    wait_idle(50);
    rd("ptr_after_2", SEL_PTR, 16'h0102);
    check("hold_addr", 32'(fb_addr), 32'h101);
    check("hold_data", 32'(fb_data), 32'hBB);

    // Read and write of PTR in the same cycle returns the old pointer.
    cpu_sel = SEL_PTR; cpu_wdata = 16'h0123; cpu_we = 1'b1; cpu_re = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b0;
    check("rw_same_cycle", 32'(cpu_rdata), 32'h102);
    ptr_m = 12'h123;
    rd("ptr_new", SEL_PTR, 16'h0123);

    // Pointer wrap.
    wr(SEL_PTR, 16'h0FFF);
    wr(SEL_DATA, 16'h0011);
    wr(SEL_DATA, 16'h0022);
    wait_idle(50);
    rd("ptr_wrap", SEL_PTR, 16'h0001);

    // Occupancy read one cycle after a push.
    wr(SEL_PTR, 16'h0040);
    wr(SEL_DATA, 16'h003C);
    rd("occ_one", SEL_DATA, 16'h0001);
    wait_idle(50);
    rd("occ_zero", SEL_DATA, 16'h0000);

`ifdef FB_WP_VBLANK_ONLY_EN
    // Stalled drain: fill the FIFO, overflow on the ninth write.
    vblank = 1'b0;
    repeat (4) @(negedge clk);
    wr(SEL_PTR, 16'h0300);
    for (int i = 0; i < 8; i++) wr(SEL_DATA, 16'(8'h60 + i));
    check("ready_full", 32'(cpu_ready), 32'd0);
    wr(SEL_DATA, 16'h00EE, 1'b0);
    rd("status_full_ovf", SEL_STATUS, 16'h000A);
    rd("occ_full", SEL_DATA, 16'h0008);
    wr(SEL_STATUS, 16'h0000);
    rd("status_ovf_clr", SEL_STATUS, 16'h0002);
    rd("ptr_after_drop", SEL_PTR, 16'h0308);
    vblank = 1'b1;
    wait_idle(100);

    // Toggling vblank: writes only inside the synchronized window, nothing lost.
    vblank = 1'b0;
    repeat (4) @(negedge clk);
    wr(SEL_PTR, 16'h0500);
    for (int i = 0; i < 6; i++) wr(SEL_DATA, 16'(8'h90 + i));
    for (int i = 0; i < 40; i++) begin
      vblank = ((i / 3) % 2) == 1;
      @(negedge clk);
    end
    vblank = 1'b1;
    wait_idle(100);
`endif

    // DATA then FILL: ordering, drop during fill, full 4096-pulse run.
    wr(SEL_PTR, 16'h0010);
    wr(SEL_DATA, 16'h0055);
    wr(SEL_FILL, 16'h0000);
    wr(SEL_DATA, 16'h0077, 1'b0);
    rd("status_fill_ovf", SEL_STATUS, 16'h000D);
    wr(SEL_STATUS, 16'h0000);
    rd("status_fill_busy", SEL_STATUS, 16'h0005);
    wait_idle(6000);
    check("fill_run_len", 32'(last_run), 32'd4096);
    rd("status_fill_done", SEL_STATUS, 16'h0001);
    rd("ptr_after_fill", SEL_PTR, 16'h0011);

    // Fill latency from an empty FIFO, then reset mid-fill.
    wr(SEL_FILL, 16'h00A5);
    check("fill_lat_e1", 32'(fb_we), 32'd0);
    @(negedge clk);
    check("fill_lat_e2_we", 32'(fb_we), 32'd1);
    check("fill_lat_e2_addr", 32'(fb_addr), 32'h000);
    begin
      int n = 0;
      while (!(fb_we === 1'b1 && fb_addr == 12'h200) && n < 6000) begin
        @(negedge clk);
        n++;
      end
      check("reach_0x200", 32'(n < 6000), 32'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_fb_we", 32'(fb_we), 32'd0);
    check("abort_fb_addr", 32'(fb_addr), 32'd0);
    check("abort_fb_data", 32'(fb_data), 32'd0);
    check("abort_rdata", 32'(cpu_rdata), 32'd0);
    check("abort_ready", 32'(cpu_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = '0;
    repeat (3) @(negedge clk);
    check("no_we_after_abort", 32'(fb_we), 32'd0);
    rd("status_after_abort", SEL_STATUS, 16'h0001);
    rd("ptr_after_abort", SEL_PTR, 16'h0000);
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
